pio_arb_master: RTL and testbench

Parametrised multi-channel PIO bus master. It arbitrates round-robin among NUM_CH requesters and issues one command at a time onto the shared PIO bus (cmd_vld/addr/data_w/rw). For reads it waits for rd_vld, with a timeout, and routes the response back to the originating channel. It also drives drv_en, which gates supply-strength override of the bus nets when RTL and testbench share them.

---
 rtl/pio_arb_master.sv | 159 +++++++++++++++
 tb/tb_pio_arb_master.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_arb_master.sv
// Round-robin PIO bus master: grant in IDLE, command 1 cycle later, response 1 cycle after write / rd_vld / timeout.
// Requesters are backpressured by a one-hot req_rdy that is only offered in IDLE; responses cannot be stalled.
module pio_arb_master #(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        req_vld,
    output logic [NUM_CH-1:0]        req_rdy,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*DATA_W-1:0] req_wdata,
    input  logic [NUM_CH-1:0]        req_rw,
    output logic [NUM_CH-1:0]        rsp_vld,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic                     cmd_vld,
    output logic [ADDR_W-1:0]        addr,
    output logic [DATA_W-1:0]        data_w,
    output logic                     rw,
    output logic                     drv_en,
    input  logic [DATA_W-1:0]        data_r,
    input  logic                     rd_vld
);
    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT_RD = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [GW-1:0]     last_q, last_d;
    logic [GW-1:0]     ch_q, ch_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rw_q, rw_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    // Rotate the request vector so bit 0 is the channel after last_grant.
    logic [2*NUM_CH-1:0] req_dbl;
    logic [NUM_CH-1:0]   req_rot;
    logic [GW:0]         rot_amt;
    logic                grant_any;
    logic [GW-1:0]       grant_idx;
    int                  grant_off;
    int                  grant_sum;

    assign req_dbl = {req_vld, req_vld};
    assign rot_amt = {1'b0, last_q} + (GW+1)'(1);
    assign req_rot = NUM_CH'(req_dbl >> rot_amt);

    always_comb begin
        grant_any = 1'b0;
        grant_off = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                grant_any = 1'b1;
                grant_off = i;
            end
        end
        grant_sum = int'(rot_amt) + grant_off;
        if (grant_sum >= NUM_CH) begin
            grant_sum = grant_sum - NUM_CH;
        end
        grant_idx = GW'(grant_sum);
    end

    always_comb begin
        req_rdy = '0;
        if (reset && state_q == S_IDLE && grant_any) begin
            req_rdy = NUM_CH'(1) << grant_idx;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        ch_d    = ch_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rw_d    = rw_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    ch_d    = grant_idx;
                    last_d  = grant_idx;
                    addr_d  = req_addr[grant_idx*ADDR_W +: ADDR_W];
                    wdata_d = req_wdata[grant_idx*DATA_W +: DATA_W];
                    rw_d    = req_rw[grant_idx];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Writes respond with zero data and no error, so clear here for both directions.
                cnt_d   = '0;
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = rw_q ? S_RESP : S_WAIT_RD;
            end
            S_WAIT_RD: begin
                if (rd_vld) begin
                    rdata_d = data_r;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            last_q  <= GW'(NUM_CH - 1);
            ch_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            ch_q    <= ch_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign cmd_vld   = (state_q == S_ISSUE);
    assign drv_en    = cmd_vld;
    assign addr      = cmd_vld ? addr_q : '0;
    assign data_w    = cmd_vld ? wdata_q : '0;
    assign rw        = cmd_vld & rw_q;
    assign rsp_vld   = (state_q == S_RESP) ? (NUM_CH'(1) << ch_q) : '0;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
endmodule

// File: tb/tb_pio_arb_master.sv
// Bench for pio_arb_master: vector table, hand-written reset/rotation/stray-rd_vld sequences, random transactions.
module tb_pio_arb_master;
    localparam int NUM_CH  = 4;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_CH-1:0]        req_vld;
    logic [NUM_CH-1:0]        req_rdy;
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH*DATA_W-1:0] req_wdata;
    logic [NUM_CH-1:0]        req_rw;
    logic [NUM_CH-1:0]        rsp_vld;
    logic [DATA_W-1:0]        rsp_rdata;
    logic                     rsp_err;
    logic                     cmd_vld;
    logic [ADDR_W-1:0]        addr;
    logic [DATA_W-1:0]        data_w;
    logic                     rw;
    logic                     drv_en;
    logic [DATA_W-1:0]        data_r;
    logic                     rd_vld;

    pio_arb_master #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr), .req_wdata(req_wdata), .req_rw(req_rw),
        .rsp_vld(rsp_vld), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .cmd_vld(cmd_vld), .addr(addr), .data_w(data_w), .rw(rw), .drv_en(drv_en),
        .data_r(data_r), .rd_vld(rd_vld)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;
    int model_last = NUM_CH - 1;

    typedef struct {
        logic [NUM_CH-1:0] mask;
        logic              rwb;
        logic [15:0]       a;
        logic [31:0]       wd;
        int                k;
        logic [31:0]       rd;
        int                exp_ch;
        int                exp_lat;
        logic              exp_err;
        logic [31:0]       exp_rdata;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first requesting channel after the last granted one, wrapping.
    function automatic int pick(input logic [NUM_CH-1:0] m, input int last);
        for (int o = 1; o <= NUM_CH; o++) begin
            int c;
            c = (last + o) % NUM_CH;
            if (m[c]) return c;
        end
        return -1;
    endfunction

    task automatic setup_bus(input int ch, input logic rwb, input logic [15:0] a, input logic [31:0] wd);
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom, $urandom, $urandom};
        req_rw    = NUM_CH'($urandom);
        req_addr[ch*ADDR_W +: ADDR_W]  = a;
        req_wdata[ch*DATA_W +: DATA_W] = wd;
        req_rw[ch] = rwb;
    endtask

    // k = WAIT_RD cycle (1-based after the command) in which rd_vld pulses; 0 = never.
    task automatic run_txn(input logic [NUM_CH-1:0] mask, input int k, input logic [31:0] rd_data,
                           input int exp_ch, input logic [15:0] exp_addr, input logic [31:0] exp_wdata,
                           input logic exp_rw, input int exp_lat, input logic exp_err,
                           input logic [31:0] exp_rdata);
        logic [NUM_CH-1:0] oh;
        int lat;
        oh  = NUM_CH'(1) << exp_ch;
        lat = -1;
        req_vld = mask;
        #1;
        chk("grant", req_rdy, oh);
        tick();
        req_vld   = '0;
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom, $urandom, $urandom};
        req_rw    = NUM_CH'($urandom);
        #1;
        chk("issue_cmd", {cmd_vld, drv_en, rw, req_rdy}, {1'b1, 1'b1, exp_rw, 4'b0});
        chk("issue_addr", addr, exp_addr);
        chk("issue_wdata", data_w, exp_wdata);
        for (int c = 1; c <= TIMEOUT + 4; c++) begin
            tick();
            rd_vld = (c == k);
            data_r = (c == k) ? rd_data : $urandom;
            #1;
            if (rsp_vld != '0) begin
                lat = c;
                break;
            end
        end
        rd_vld = 1'b0;
        chk("rsp_latency", lat, exp_lat);
        chk("rsp_vld", rsp_vld, oh);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_cmd_low", {cmd_vld, drv_en}, 2'b00);
        tick();
        #1;
        chk("rsp_one_cycle", rsp_vld, 0);
        model_last = exp_ch;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        model_last = NUM_CH - 1;
    endtask

    initial begin
        int gch[$];
        int gcyc[$];
        vecs[0] = '{4'b0001, 1'b1, 16'h0010, 32'hCAFE_F00D, 0,  32'h0,         0, 1,  1'b0, 32'h0};
        vecs[1] = '{4'b0100, 1'b0, 16'h0200, 32'h0,         3,  32'h1234_5678, 2, 4,  1'b0, 32'h1234_5678};
        vecs[2] = '{4'b0010, 1'b0, 16'h0030, 32'h0,         0,  32'h0,         1, 17, 1'b1, 32'h0};
        vecs[3] = '{4'b0010, 1'b0, 16'h0031, 32'h0,         16, 32'hA5A5_5A5A, 1, 17, 1'b0, 32'hA5A5_5A5A};
        vecs[4] = '{4'b0010, 1'b0, 16'h0032, 32'h0,         17, 32'hFFFF_0000, 1, 17, 1'b1, 32'h0};
        vecs[5] = '{4'b1010, 1'b0, 16'hBEE0, 32'h0,         1,  32'h0BAD_BEEF, 3, 2,  1'b0, 32'h0BAD_BEEF};
        vecs[6] = '{4'b1010, 1'b1, 16'h1111, 32'h7777_8888, 1,  32'h5555_5555, 1, 1,  1'b0, 32'h0};
        vecs[7] = '{4'b1111, 1'b1, 16'h2222, 32'h9999_AAAA, 0,  32'h0,         2, 1,  1'b0, 32'h0};
        vecs[8] = '{4'b1001, 1'b0, 16'h3333, 32'h0,         15, 32'h1111_2222, 3, 16, 1'b0, 32'h1111_2222};

        reset = 1'b0; req_vld = '0; req_addr = '0; req_wdata = '0; req_rw = '0;
        data_r = '0; rd_vld = 1'b0;
        #2;
        chk("reset_outputs", {req_rdy, rsp_vld, rsp_rdata, rsp_err, cmd_vld, addr, data_w, rw, drv_en}, 0);
        #10;
        reset = 1'b1;
        tick();

        foreach (vecs[i]) begin
            setup_bus(vecs[i].exp_ch, vecs[i].rwb, vecs[i].a, vecs[i].wd);
            run_txn(vecs[i].mask, vecs[i].k, vecs[i].rd, vecs[i].exp_ch, vecs[i].a,
                    vecs[i].wd, vecs[i].rwb, vecs[i].exp_lat, vecs[i].exp_err, vecs[i].exp_rdata);
        end

        // Reset during ISSUE must drop the command immediately.
        do_reset();
        setup_bus(1, 1'b0, 16'h4444, 32'h0);
        req_vld = 4'b0010;
        #1;
        tick();
        req_vld = '0;
        #1;
        chk("rst_issue_cmd", cmd_vld, 1);
        reset = 1'b0;
        #1;
        chk("rst_issue_clear", {cmd_vld, drv_en, addr, data_w, rw}, 0);
        #1;
        reset = 1'b1;
        tick();

        // Reset during WAIT_RD, then a late rd_vld.
        req_vld = 4'b0010;
        #1;
        tick();
        req_vld = '0;
        tick();
        tick();
        #1;
        reset = 1'b0;
        #1;
        chk("rst_wait_clear", {req_rdy, rsp_vld, rsp_rdata, rsp_err, cmd_vld, addr, data_w, rw, drv_en}, 0);
        #1;
        reset = 1'b1;
        model_last = NUM_CH - 1;
        rd_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_r = $urandom;
            #1;
            chk("late_rd_vld", {rsp_vld, rsp_rdata, rsp_err}, 0);
            tick();
        end
        rd_vld = 1'b0;
        setup_bus(0, 1'b1, 16'h5555, 32'h1357_9BDF);
        run_txn(4'b1111, 0, 32'h0, 0, 16'h5555, 32'h1357_9BDF, 1'b1, 1, 1'b0, 32'h0);

        // All channels requesting writes continuously: strict rotation, one grant every 3 cycles.
        do_reset();
        req_vld = 4'b1111;
        req_rw  = 4'b1111;
        for (int cyc = 0; cyc < 18; cyc++) begin
            #1;
            for (int b = 0; b < NUM_CH; b++) begin
                if (req_rdy[b]) begin
                    gch.push_back(b);
                    gcyc.push_back(cyc);
                end
            end
            tick();
        end
        req_vld = '0;
        chk("rr_count", gch.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < gch.size()) begin
                chk("rr_channel", gch[i], i % NUM_CH);
                chk("rr_cycle", gcyc[i], 3 * i);
            end
        end
        model_last = 1;

        // rd_vld while idle must not disturb the held read data.
        setup_bus(2, 1'b0, 16'h6666, 32'h0);
        run_txn(4'b0100, 2, 32'h600D_F00D, 2, 16'h6666, 32'h0, 1'b0, 3, 1'b0, 32'h600D_F00D);
        rd_vld = 1'b1;
        data_r = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("idle_rd_vld", {rsp_vld, rsp_rdata}, {4'b0, 32'h600D_F00D});
            tick();
        end
        rd_vld = 1'b0;

        for (int n = 0; n < 40; n++) begin
            logic [NUM_CH-1:0] m;
            int ec, k, elat;
            logic erw, eerr;
            logic [31:0] rdv, erd;
            m = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
            req_addr  = {$urandom, $urandom};
            req_wdata = {$urandom, $urandom, $urandom, $urandom};
            req_rw    = NUM_CH'($urandom);
            ec  = pick(m, model_last);
            k   = $urandom_range(0, TIMEOUT + 2);
            rdv = $urandom;
            erw = req_rw[ec];
            if (erw) begin
                elat = 1; eerr = 1'b0; erd = '0;
            end else if (k >= 1 && k <= TIMEOUT) begin
                elat = k + 1; eerr = 1'b0; erd = rdv;
            end else begin
                elat = TIMEOUT + 1; eerr = 1'b1; erd = '0;
            end
            run_txn(m, k, rdv, ec, req_addr[ec*ADDR_W +: ADDR_W], req_wdata[ec*DATA_W +: DATA_W],
                    erw, elat, eerr, erd);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
